// File: rtl/ll_fifo_sched_if.sv
// Producer/consumer stream bundle for ll_fifo_sched: NUM_FIFOS producer lanes
// in, one tagged output stream out.
interface ll_fifo_sched_if #(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
);
  logic [NUM_FIFOS-1:0]       in_valid;
  logic [NUM_FIFOS*WIDTH-1:0] in_data;
  logic [NUM_FIFOS-1:0]       in_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic [SEL_WIDTH-1:0]       out_sel;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/ll_fifo_sched.sv
// Round-robin push/pop scheduler in front of a shared linked_list_fifo, with
// per-queue quota and a 2-entry credit-controlled output buffer.

module ll_fifo_sched_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst)              count <= '0;
    else if (inc && !dec) count <= count + CW'(1);
    else if (dec && !inc) count <= count - CW'(1);
  end
endmodule

module ll_fifo_sched #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int NUM_FIFOS = 2,
  parameter int QUOTA     = DEPTH,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  ll_fifo_sched_if.slave                       io,
  output logic                                 ll_push,
  output logic                                 ll_pop,
  output logic [SEL_WIDTH-1:0]                 ll_push_sel,
  output logic [SEL_WIDTH-1:0]                 ll_pop_sel,
  output logic [WIDTH-1:0]                     ll_data_in,
  input  logic                                 ll_full,
  input  logic [NUM_FIFOS-1:0]                 ll_empty,
  input  logic [WIDTH-1:0]                     ll_data_out,
  output logic [NUM_FIFOS*(PTR_WIDTH+1)-1:0]   fifo_count
);
  localparam int CW = PTR_WIDTH + 1;

  typedef struct packed {
    logic [WIDTH-1:0]     data;
    logic [SEL_WIDTH-1:0] sel;
  } ent_t;

  logic [NUM_FIFOS-1:0][CW-1:0] count;
  logic [CW-1:0]                total;
  logic [SEL_WIDTH-1:0]         push_rr, pop_rr, push_g, pop_g, inflt_sel;
  logic [NUM_FIFOS-1:0]         elig_push, elig_pop, cnt_zero, push_hot, pop_hot;
  logic [SEL_WIDTH:0]           push_pick, pop_pick;
  logic                         push_any, pop_any, credit, drain, inflt;
  logic [1:0]                   occ;
  ent_t [1:0]                   obuf;
  ent_t                         land_e;

  // Returns {found, index}: first requester at or after rr, cyclically.
  function automatic logic [SEL_WIDTH:0] rr_pick(input logic [NUM_FIFOS-1:0] req,
                                                 input logic [SEL_WIDTH-1:0] rr);
    logic                 found;
    logic [SEL_WIDTH-1:0] idx;
    int                   j;
    found = 1'b0;
    idx   = rr;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      j = int'(rr) + k;
      if (j >= NUM_FIFOS) j -= NUM_FIFOS;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = SEL_WIDTH'(j);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [SEL_WIDTH-1:0] rr_next(input logic [SEL_WIDTH-1:0] s);
    return (s == SEL_WIDTH'(NUM_FIFOS-1)) ? '0 : s + SEL_WIDTH'(1);
  endfunction

  // Eligibility looks only at registered state: a same-cycle pop never frees room.
  always_comb begin
    for (int i = 0; i < NUM_FIFOS; i++) begin
      elig_push[i] = io.in_valid[i] && (count[i] < CW'(QUOTA)) && (total < CW'(DEPTH));
      elig_pop[i]  = (count[i] != '0);
      cnt_zero[i]  = (count[i] == '0);
    end
  end

  assign drain     = io.out_valid && io.out_ready;
  assign credit    = (({1'b0, occ} + {2'b0, inflt}) - {2'b0, drain}) < 3'd2;
  assign push_pick = rr_pick(elig_push, push_rr);
  assign pop_pick  = rr_pick(elig_pop, pop_rr);
  assign push_any  = push_pick[SEL_WIDTH] && !rst;
  assign pop_any   = pop_pick[SEL_WIDTH] && credit && !rst;
  assign push_g    = push_pick[SEL_WIDTH-1:0];
  assign pop_g     = pop_pick[SEL_WIDTH-1:0];
  assign push_hot  = push_any ? (NUM_FIFOS'(1) << push_g) : '0;
  assign pop_hot   = pop_any  ? (NUM_FIFOS'(1) << pop_g)  : '0;

  assign io.in_ready  = push_hot;
  assign ll_push      = push_any;
  assign ll_push_sel  = push_g;
  assign ll_data_in   = io.in_data[push_g*WIDTH +: WIDTH];
  assign ll_pop       = pop_any;
  assign ll_pop_sel   = pop_g;

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_q
    ll_fifo_sched_cnt #(.CW(CW)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (push_hot[g]),
      .dec   (pop_hot[g]),
      .count (count[g])
    );
    assign fifo_count[g*CW +: CW] = count[g];
  end

  always_ff @(posedge clk) begin
    if (rst)                    total <= '0;
    else if (push_any && !pop_any) total <= total + CW'(1);
    else if (pop_any && !push_any) total <= total - CW'(1);
  end

  assign land_e = {ll_data_out, inflt_sel};

  always_ff @(posedge clk) begin
    if (rst) begin
      push_rr   <= '0;
      pop_rr    <= '0;
      inflt     <= 1'b0;
      inflt_sel <= '0;
      occ       <= 2'd0;
      obuf      <= '0;
    end else begin
      inflt <= pop_any;
      if (pop_any) begin
        inflt_sel <= pop_g;
        pop_rr    <= rr_next(pop_g);
      end
      if (push_any) push_rr <= rr_next(push_g);
      // Landing without drain only ever happens with occ <= 1 thanks to the credit.
      case ({inflt, drain})
        2'b01: begin
          obuf[0] <= obuf[1];
          occ     <= occ - 2'd1;
        end
        2'b10: begin
          obuf[occ[0]] <= land_e;
          occ          <= occ + 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) obuf[0] <= land_e;
          else begin
            obuf[0] <= obuf[1];
            obuf[1] <= land_e;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.out_valid = (occ != 2'd0);
  assign io.out_data  = obuf[0].data;
  assign io.out_sel   = obuf[0].sel;

  a_empty: assert property (@(posedge clk) disable iff (rst) ll_empty == cnt_zero);
  a_full:  assert property (@(posedge clk) disable iff (rst) ll_full == (total == CW'(DEPTH)));
  a_cred:  assert property (@(posedge clk) disable iff (rst) ({1'b0, occ} + {2'b0, inflt}) <= 3'd2);
endmodule

// File: tb/tb_ll_fifo_sched.sv
// Randomized bench for ll_fifo_sched with a behavioural shared-FIFO stand-in,
// a rule-level reference model and an output scoreboard.
module tb_ll_fifo_sched;
  localparam int WIDTH = 8, DEPTH = 4, NUM_FIFOS = 2, QUOTA = 3;
  localparam int PW = $clog2(DEPTH), SW = $clog2(NUM_FIFOS), CW = PW + 1;
  localparam int DW = NUM_FIFOS * WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [SW-1:0]    s;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ll_fifo_sched_if #(.WIDTH(WIDTH), .NUM_FIFOS(NUM_FIFOS), .SEL_WIDTH(SW)) io ();

  logic                     ll_push, ll_pop, ll_full;
  logic [SW-1:0]            ll_push_sel, ll_pop_sel;
  logic [WIDTH-1:0]         ll_data_in, ll_data_out;
  logic [NUM_FIFOS-1:0]     ll_empty;
  logic [NUM_FIFOS*CW-1:0]  fifo_count;

  ll_fifo_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_FIFOS(NUM_FIFOS), .QUOTA(QUOTA)) dut (
    .clk(clk), .rst(rst), .io(io),
    .ll_push(ll_push), .ll_pop(ll_pop), .ll_push_sel(ll_push_sel), .ll_pop_sel(ll_pop_sel),
    .ll_data_in(ll_data_in), .ll_full(ll_full), .ll_empty(ll_empty),
    .ll_data_out(ll_data_out), .fifo_count(fifo_count)
  );

  int checks = 0, failures = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Stand-in for the shared linked_list_fifo: per-queue queues, registered data_out.
  logic [WIDTH-1:0] env_q [NUM_FIFOS][$];
  always @(posedge clk) begin : env
    int tot;
    if (rst) begin
      for (int i = 0; i < NUM_FIFOS; i++) env_q[i].delete();
      ll_data_out <= '0;
      ll_empty    <= '1;
      ll_full     <= 1'b0;
    end else begin
      if (ll_pop && env_q[ll_pop_sel].size() != 0) ll_data_out <= env_q[ll_pop_sel].pop_front();
      if (ll_push) env_q[ll_push_sel].push_back(ll_data_in);
      tot = 0;
      for (int i = 0; i < NUM_FIFOS; i++) begin
        ll_empty[i] <= (env_q[i].size() == 0);
        tot += env_q[i].size();
      end
      ll_full <= (tot == DEPTH);
    end
  end

  // Reference model state, at the level of queue contents and occupancy numbers.
  int               m_cnt [NUM_FIFOS];
  int               m_prr = 0, m_pprr = 0, m_occ = 0;
  bit               m_inflt = 0;
  logic [WIDTH-1:0] mq [NUM_FIFOS][$];
  ent_t             exp_q [$];

  function automatic bit model_idle();
    int s;
    s = 0;
    for (int i = 0; i < NUM_FIFOS; i++) s += m_cnt[i];
    return (s == 0) && (m_occ == 0) && !m_inflt && (exp_q.size() == 0);
  endfunction

  always @(negedge clk) begin : model
    int pg, pp, tot, ii;
    bit drn;
    logic [NUM_FIFOS-1:0] exp_rdy;
    ent_t e;
    if (rst) begin
      chk("rst_in_ready", io.in_ready, 0);
      chk("rst_ll_push", ll_push, 0);
      chk("rst_ll_pop", ll_pop, 0);
      for (int i = 0; i < NUM_FIFOS; i++) begin
        m_cnt[i] = 0;
        mq[i].delete();
      end
      m_prr = 0; m_pprr = 0; m_occ = 0; m_inflt = 0;
      exp_q.delete();
    end else begin
      tot = 0;
      for (int i = 0; i < NUM_FIFOS; i++) tot += m_cnt[i];
      drn = (m_occ != 0) && io.out_ready;
      pg = -1;
      for (int k = 0; k < NUM_FIFOS; k++) begin
        ii = (m_prr + k) % NUM_FIFOS;
        if (pg < 0 && io.in_valid[ii] && m_cnt[ii] < QUOTA && tot < DEPTH) pg = ii;
      end
      pp = -1;
      if (m_occ + int'(m_inflt) - int'(drn) < 2)
        for (int k = 0; k < NUM_FIFOS; k++) begin
          ii = (m_pprr + k) % NUM_FIFOS;
          if (pp < 0 && m_cnt[ii] != 0) pp = ii;
        end

      exp_rdy = '0;
      if (pg >= 0) exp_rdy[pg] = 1'b1;
      chk("out_valid", io.out_valid, m_occ != 0);
      chk("in_ready", io.in_ready, exp_rdy);
      chk("ll_push", ll_push, pg >= 0);
      if (pg >= 0) begin
        chk("ll_push_sel", ll_push_sel, pg);
        chk("ll_data_in", ll_data_in, io.in_data[pg*WIDTH +: WIDTH]);
      end
      chk("ll_pop", ll_pop, pp >= 0);
      if (pp >= 0) chk("ll_pop_sel", ll_pop_sel, pp);
      for (int i = 0; i < NUM_FIFOS; i++) begin
        chk("fifo_count", fifo_count[i*CW +: CW], m_cnt[i]);
        chk("ll_empty", ll_empty[i], m_cnt[i] == 0);
      end
      chk("ll_full", ll_full, tot == DEPTH);

      if (m_inflt) m_occ++;
      if (drn) m_occ--;
      m_inflt = (pp >= 0);
      if (pp >= 0) begin
        e.d = mq[pp].pop_front();
        e.s = SW'(pp);
        exp_q.push_back(e);
        m_cnt[pp]--;
        m_pprr = (pp + 1) % NUM_FIFOS;
      end
      if (pg >= 0) begin
        mq[pg].push_back(io.in_data[pg*WIDTH +: WIDTH]);
        m_cnt[pg]++;
        m_prr = (pg + 1) % NUM_FIFOS;
      end
    end
  end

  // Output scoreboard: every consumed word must be the oldest predicted pop.
  always @(negedge clk) begin : monitor
    ent_t e;
    if (!rst && io.out_valid && io.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected: got %0h/%0h expected nothing", io.out_data, io.out_sel);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", io.out_data, e.d);
        chk("out_sel", io.out_sel, e.s);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    io.in_valid = '0;
    io.out_ready = 1'b1;
    rst = 1'b0;
    while (!model_idle() && n < 100) begin
      cycle();
      n++;
    end
    chk("drain_done", model_idle(), 1);
  endtask

  initial begin : stim
    int t0, lat;
    bit saw;
    io.in_valid = '0;
    io.in_data = '0;
    io.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single push on queue 1: pop at +1, visible at +3.
    io.in_valid = 2'b10;
    io.in_data = {8'hA5, 8'h00};
    t0 = cyc;
    cycle();
    io.in_valid = '0;
    lat = -1;
    for (int c = 0; c < 8 && lat < 0; c++) begin
      @(negedge clk);
      if (io.out_valid) lat = cyc - t0;
    end
    chk("latency", lat, 3);
    chk("first_data", io.out_data, 8'hA5);
    chk("first_sel", io.out_sel, 1);
    drain();

    // Both producers streaming with a free consumer.
    for (int n = 0; n < 16; n++) begin
      io.in_valid = 2'b11;
      io.in_data = DW'($urandom);
      cycle();
    end
    drain();

    // Quota: only producer 0 with the consumer stalled.
    io.out_ready = 1'b0;
    io.in_valid = 2'b01;
    for (int n = 0; n < 10; n++) begin
      io.in_data = DW'($urandom);
      cycle();
    end
    @(negedge clk);
    chk("quota_cnt0", fifo_count[CW-1:0], QUOTA);
    chk("quota_block", io.in_ready, 0);
    chk("quota_occ2_valid", io.out_valid, 1);
    chk("quota_no_pop", ll_pop, 0);
    cycle();
    io.in_valid = 2'b11;
    @(negedge clk);
    chk("quota_other", io.in_ready, 2'b10);
    cycle();
    @(negedge clk);
    chk("full_flag", ll_full, 1);
    chk("full_block", io.in_ready, 0);

    // One drain frees an entry and one more push follows.
    cycle();
    io.out_ready = 1'b1;
    cycle();
    io.out_ready = 1'b0;
    saw = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (io.in_ready != 0) saw = 1;
      cycle();
    end
    chk("push_after_drain", saw, 1);

    // Reset with a full output buffer drops everything.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    io.in_valid = '0;
    @(negedge clk);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_counts", fifo_count, 0);
    chk("rst_out_data", io.out_data, 0);
    drain();

    // Random traffic with backpressure phases and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      cycle();
      rst = ($urandom_range(0, 299) == 0);
      io.in_valid = NUM_FIFOS'($urandom);
      io.in_data = DW'($urandom);
      io.out_ready = (((n / 64) % 3) == 2) ? ($urandom_range(0, 3) == 0)
                                            : ($urandom_range(0, 3) != 0);
    end
    cycle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ll_fifo_sched.md
# ll_fifo_sched

Round-robin scheduler that shares one `linked_list_fifo` instance among `NUM_FIFOS` producer ports and one consumer port. It issues at most one push and one pop per cycle to the shared FIFO. A per-queue occupancy quota stops any single queue from exhausting the shared entry pool. Popped data goes into a 2-entry output buffer with valid/ready flow control. The block sits directly in front of `linked_list_fifo`, drives all of its request inputs, and shares its clock and reset.

## Interface
- `WIDTH`, 8, data width.
- `DEPTH`, 4, total entries of the shared linked-list FIFO.
- `NUM_FIFOS`, 2, number of logical queues and producer ports.
- `QUOTA`, `DEPTH`, maximum entries one queue may hold; legal range 1..`DEPTH`.
- `PTR_WIDTH`, `$clog2(DEPTH)`; `SEL_WIDTH`, `$clog2(NUM_FIFOS)`.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  `NUM_FIFOS`  producer i has data for queue i.
- `in_data`  in  `NUM_FIFOS*WIDTH`  producer data; slice i = `[i*WIDTH +: WIDTH]`.
- `in_ready`  out  `NUM_FIFOS`  one-hot or zero; producer i accepted this cycle.
- `out_valid`  out  1  head of output buffer valid.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  `WIDTH`  head data.
- `out_sel`  out  `SEL_WIDTH`  queue the head came from.
- `ll_push`, `ll_pop`  out  1  to shared FIFO `push`/`pop`.
- `ll_push_sel`, `ll_pop_sel`  out  `SEL_WIDTH`  to shared FIFO `push_sel`/`pop_sel`.
- `ll_data_in`  out  `WIDTH`  to shared FIFO `data_in`.
- `ll_full`  in  1  shared FIFO `full`.
- `ll_empty`  in  `NUM_FIFOS`  shared FIFO `empty`.
- `ll_data_out`  in  `WIDTH`  shared FIFO `data_out`; valid the cycle after `ll_pop`.
- `fifo_count`  out  `NUM_FIFOS*(PTR_WIDTH+1)`  per-queue occupancy, registered.

## Operation
- State:
  - per-queue counters `count[i]`, each `PTR_WIDTH+1` bits;
  - `total`, the sum of the counters;
  - push round-robin pointer `push_rr`;
  - pop round-robin pointer `pop_rr`;
  - in-flight flag `inflt` with its queue id `inflt_sel`;
  - 2-entry output buffer (data+sel), with `occ` in 0..2.
- Push eligibility: `elig_push[i] = in_valid[i] & (count[i] < QUOTA) & (total < DEPTH)`. The check uses registered state only, so there is no push while full even if a pop happens in the same cycle.
- Push grant:
  - Grant the first eligible i at or after `push_rr`, searching cyclically.
  - Drive `ll_push=1`, `ll_push_sel=i`, `ll_data_in=in_data[i]`, `in_ready[i]=1`.
  - Next cycle, `push_rr = i+1` mod `NUM_FIFOS`. The pointer is unchanged when nothing is granted.
- Pop eligibility:
  - `elig_pop[i] = (count[i] != 0)`.
  - Credit condition: `occ + inflt - (out_valid & out_ready) < 2`.
  - Grant the first eligible i at or after `pop_rr`. Drive `ll_pop=1` and `ll_pop_sel=i`. Set `inflt=1` and `inflt_sel=i`; `pop_rr` advances the same way as `push_rr`.
- Landing: in the cycle with `inflt=1`, `{ll_data_out, inflt_sel}` is written into the output buffer at the end of that cycle.
- Counters:
  - `count[i]` +1 on a push to i, -1 on a pop from i, unchanged on both.
  - `total` tracks the sum. A push to i while `count[i]==0` is not poppable until the next cycle.
- Output buffer is FIFO-ordered; `out_valid = (occ != 0)`. Simultaneous land and drain keeps `occ` unchanged.
- Consistency invariants, for formal/bench checks:
  - `ll_empty[i] == (count[i]==0)`;
  - `ll_full == (total==DEPTH)`;
  - `count[i] <= QUOTA`;
  - `occ + inflt <= 2`.
- `in_ready` depends combinationally on `in_valid`; producers must not make `in_valid` depend on `in_ready`.
- `ll_pop` depends combinationally on `out_ready`.

## Timing
- Reset values:
  - `count`, `total`, `occ`, `inflt`, `push_rr`, `pop_rr` = 0.
  - `out_valid=0`, `out_data=0`, `out_sel=0`, `fifo_count=0`.
  - `in_ready=0`, `ll_push=0`, `ll_pop=0` while `rst` is high.
- Reset mid-operation drops all buffered and in-flight data; the shared FIFO is reset on the same `rst`.
- Push accepted in cycle t:
  - `fifo_count` updates at t+1;
  - earliest `ll_pop` is at t+1;
  - data lands at the t+2 edge;
  - `out_valid` is asserted in cycle t+3.
- Sustained throughput is 1 push and 1 pop per cycle with `out_ready=1`.
- With `out_ready=0`, at most 2 entries are buffered or in flight; no loss, no duplication.

## Test plan
- Reset, then one push on queue 1 with `in_data` 0xA5 at cycle 0 -> `ll_push_sel=1`; `ll_pop` at cycle 1; `out_valid=1`, `out_data=0xA5`, `out_sel=1` at cycle 3.
- Both producers valid continuously, `NUM_FIFOS=2`, `QUOTA=4`, `out_ready=1` -> grants alternate 0,1,0,1; pops alternate once both counts are nonzero.
- `QUOTA=2`, only producer 0 valid -> `in_ready[0]` drops after 2 accepts while `total=2 < DEPTH`; producer 1 is still accepted.
- `QUOTA=4`, fill `DEPTH=4` -> `ll_full=1`, all `in_ready=0`; after one drain, one more push is accepted.
- Hold `out_ready=0` with queues non-empty -> exactly 2 pops issued, `occ=2`, no further `ll_pop`; release -> data emerges in pop order, none lost.
- Assert `rst` for one cycle with `occ=2` and `inflt=1` -> next cycle `out_valid=0`, all counts 0, `push_rr=pop_rr=0`.
